// File: rtl/input_capture_pkg.sv
// input_capture_pkg: shared constants and entry layout for the input capture block
package input_capture_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int SYNC_STAGES = 2;

    // Entry layout at the default widths; the FIFO stores the same fields packed as {stamp, ovf, rising}
    typedef struct packed {
        logic [31:0] stamp;
        logic [7:0]  ovf;
        logic        rising;
    } cap_entry_t;

endpackage

// File: rtl/cap_fifo.sv
// cap_fifo: synchronous FIFO with a registered head, level and full; accepts push+pop when full
module cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d, after_pop;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop;

    // Next pointers/level; the head reloads from the entry that will be oldest after this cycle
    always_comb begin
        do_pop    = pop_i & (|level_q);
        after_pop = level_q - (AW+1)'(do_pop);
        wr_ptr_d  = wr_ptr_q + AW'(push_i);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        level_d   = after_pop + (AW+1)'(push_i);
        head_d    = ~|after_pop ? (push_i ? din_i : head_q) : mem_q[rd_ptr_d];
    end

    // Storage array, written at the tail; never read back in the push cycle
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer, level and head registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = |level_q;
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign level_o = level_q;

endmodule

// File: rtl/input_capture.sv
// input_capture: timestamps edges of an async input against the timer and queues them for a consumer
module input_capture
    import input_capture_pkg::*;
#(
    parameter int COUNTER_SIZE = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int OVF_BITS     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [1:0]                    edge_mode,
    input  logic                          cap_in,
    input  logic [COUNTER_SIZE-1:0]       timebase,
    input  logic                          timebase_ovf,
    input  logic                          rd_ready,
    input  logic                          clear_lost,
    output logic                          rd_valid,
    output logic [COUNTER_SIZE-1:0]       rd_stamp,
    output logic [OVF_BITS-1:0]           rd_ovf,
    output logic                          rd_rising,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          lost
);

    localparam int EW = COUNTER_SIZE + OVF_BITS + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s3_q;
    logic [1:0]             prime_cnt_q;
    logic [OVF_BITS-1:0]    acc_q, acc_d;
    logic                   lost_q, lost_d;
    logic                   primed, rise, fall, evt, pop, accept, drop, full;
    logic [EW-1:0]          head;

    assign primed = &prime_cnt_q;

    // Edge detection, FIFO handshake, overflow accumulator and sticky lost flag
    always_comb begin
        rise   = sync_q[SYNC_STAGES-1] & ~s3_q;
        fall   = ~sync_q[SYNC_STAGES-1] & s3_q;
        evt    = primed & enable &
                 ((rise & (edge_mode == EDGE_RISE || edge_mode == EDGE_BOTH)) |
                  (fall & (edge_mode == EDGE_FALL || edge_mode == EDGE_BOTH)));
        pop    = rd_valid & rd_ready;
        accept = evt & (~full | pop);
        drop   = evt & full & ~pop;
        acc_d  = accept ? OVF_BITS'(timebase_ovf) :
                 (timebase_ovf & ~&acc_q) ? acc_q + OVF_BITS'(1) : acc_q;
        lost_d = drop | (lost_q & ~clear_lost);
    end

    // Synchronizer, history flop, priming counter, accumulator and lost register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            s3_q        <= 1'b0;
            prime_cnt_q <= '0;
            acc_q       <= '0;
            lost_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], cap_in};
            s3_q        <= sync_q[SYNC_STAGES-1];
            prime_cnt_q <= primed ? prime_cnt_q : prime_cnt_q + 2'd1;
            acc_q       <= acc_d;
            lost_q      <= lost_d;
        end
    end

    cap_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .din_i   ({timebase, acc_q, rise}),
        .pop_i   (rd_ready),
        .head_o  (head),
        .valid_o (rd_valid),
        .full_o  (full),
        .level_o (level)
    );

    assign rd_stamp  = head[EW-1 -: COUNTER_SIZE];
    assign rd_ovf    = head[OVF_BITS:1];
    assign rd_rising = head[0];
    assign lost      = lost_q;

endmodule

// File: tb/tb_input_capture.sv
// tb_input_capture: directed tests for input_capture with hand-computed expectations
module tb_input_capture;

    logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, cap_in = 1'b0;
    logic        timebase_ovf = 1'b0, rd_ready = 1'b0, clear_lost = 1'b0;
    logic [1:0]  edge_mode = 2'b00;
    logic [31:0] timebase = 32'd0;
    logic        rd_valid, rd_rising, lost;
    logic [31:0] rd_stamp;
    logic [7:0]  rd_ovf;
    logic [2:0]  level;
    int          checks = 0, errors = 0;

    input_capture dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .edge_mode(edge_mode),
        .cap_in(cap_in), .timebase(timebase), .timebase_ovf(timebase_ovf),
        .rd_ready(rd_ready), .clear_lost(clear_lost), .rd_valid(rd_valid),
        .rd_stamp(rd_stamp), .rd_ovf(rd_ovf), .rd_rising(rd_rising),
        .level(level), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        timebase = timebase + 32'd1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        steps(2);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", rd_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %0d exp 0", lost); end
        checks++; if (rd_stamp !== 32'd0) begin errors++; $display("FAIL reset_stamp got %0d exp 0", rd_stamp); end
        checks++; if (rd_ovf !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", rd_ovf); end
        checks++; if (rd_rising !== 1'b0) begin errors++; $display("FAIL reset_rising got %0d exp 0", rd_rising); end
        reset_n = 1'b1;
        steps(4);
    endtask

    task automatic test_basic();
        enable = 1'b1;
        edge_mode = 2'b01;
        timebase = 32'd100;
        cap_in = 1'b1;
        steps(2);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0d exp 0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", rd_valid); end
        checks++; if (rd_stamp !== 32'd102) begin errors++; $display("FAIL basic_stamp got %0d exp 102", rd_stamp); end
        checks++; if (rd_rising !== 1'b1) begin errors++; $display("FAIL basic_rising got %0d exp 1", rd_rising); end
        checks++; if (rd_ovf !== 8'd0) begin errors++; $display("FAIL basic_ovf got %0d exp 0", rd_ovf); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d exp 1", level); end
        step();
        checks++; if (rd_stamp !== 32'd102) begin errors++; $display("FAIL basic_hold got %0d exp 102", rd_stamp); end
        pop();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %0d exp 0", rd_valid); end
        cap_in = 1'b0;
        steps(3);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_fall_ignored got %0d exp 0", level); end
    endtask

    task automatic test_both();
        edge_mode = 2'b11;
        timebase = 32'd200;
        cap_in = 1'b1;
        steps(5);
        cap_in = 1'b0;
        steps(3);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL both_level got %0d exp 2", level); end
        checks++; if (rd_stamp !== 32'd202) begin errors++; $display("FAIL both_rise_stamp got %0d exp 202", rd_stamp); end
        checks++; if (rd_rising !== 1'b1) begin errors++; $display("FAIL both_rise_pol got %0d exp 1", rd_rising); end
        pop();
        checks++; if (rd_stamp !== 32'd207) begin errors++; $display("FAIL both_fall_stamp got %0d exp 207", rd_stamp); end
        checks++; if (rd_rising !== 1'b0) begin errors++; $display("FAIL both_fall_pol got %0d exp 0", rd_rising); end
        pop();
    endtask

    task automatic test_overflow();
        edge_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            timebase_ovf = 1'b1;
            step();
            timebase_ovf = 1'b0;
            step();
        end
        cap_in = 1'b1;
        steps(3);
        checks++; if (rd_ovf !== 8'd3) begin errors++; $display("FAIL ovf_three got %0d exp 3", rd_ovf); end
        cap_in = 1'b0;
        steps(3);
        cap_in = 1'b1;
        steps(2);
        timebase_ovf = 1'b1;
        step();
        timebase_ovf = 1'b0;
        cap_in = 1'b0;
        steps(3);
        cap_in = 1'b1;
        steps(3);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL ovf_level got %0d exp 3", level); end
        pop();
        checks++; if (rd_ovf !== 8'd0) begin errors++; $display("FAIL ovf_coincident got %0d exp 0", rd_ovf); end
        pop();
        checks++; if (rd_ovf !== 8'd1) begin errors++; $display("FAIL ovf_carried got %0d exp 1", rd_ovf); end
        pop();
        cap_in = 1'b0;
        steps(3);
    endtask

    task automatic test_disable();
        enable = 1'b0;
        edge_mode = 2'b11;
        cap_in = 1'b1;
        steps(4);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL dis_captured got %0d exp 0", level); end
        enable = 1'b1;
        steps(3);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL dis_replay got %0d exp 0", level); end
        timebase = 32'd250;
        cap_in = 1'b0;
        steps(3);
        checks++; if (rd_stamp !== 32'd252) begin errors++; $display("FAIL dis_reenable_stamp got %0d exp 252", rd_stamp); end
        checks++; if (rd_rising !== 1'b0) begin errors++; $display("FAIL dis_reenable_pol got %0d exp 0", rd_rising); end
        pop();
    endtask

    task automatic test_overrun();
        edge_mode = 2'b11;
        timebase = 32'd300;
        for (int i = 0; i < 6; i++) begin
            cap_in = ~cap_in;
            steps(2);
        end
        steps(2);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d exp 4", level); end
        checks++; if (lost !== 1'b1) begin errors++; $display("FAIL ovr_lost got %0d exp 1", lost); end
        checks++; if (rd_stamp !== 32'd302) begin errors++; $display("FAIL ovr_first got %0d exp 302", rd_stamp); end
        timebase = 32'd400;
        cap_in = 1'b1;
        steps(2);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_pushpop_level got %0d exp 4", level); end
        checks++; if (rd_stamp !== 32'd304) begin errors++; $display("FAIL ovr_second got %0d exp 304", rd_stamp); end
        pop();
        checks++; if (rd_stamp !== 32'd306) begin errors++; $display("FAIL ovr_third got %0d exp 306", rd_stamp); end
        pop();
        checks++; if (rd_stamp !== 32'd308) begin errors++; $display("FAIL ovr_fourth got %0d exp 308", rd_stamp); end
        pop();
        checks++; if (rd_stamp !== 32'd402) begin errors++; $display("FAIL ovr_accepted got %0d exp 402", rd_stamp); end
        checks++; if (lost !== 1'b1) begin errors++; $display("FAIL ovr_lost_sticky got %0d exp 1", lost); end
        clear_lost = 1'b1;
        step();
        clear_lost = 1'b0;
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0d exp 0", lost); end
        pop();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovr_drain got %0d exp 0", level); end
    endtask

    task automatic test_reset_high();
        reset_n = 1'b0;
        cap_in = 1'b1;
        steps(3);
        reset_n = 1'b1;
        steps(6);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rsthi_level got %0d exp 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rsthi_valid got %0d exp 0", rd_valid); end
        timebase = 32'd500;
        cap_in = 1'b0;
        steps(3);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rsthi_fall_valid got %0d exp 1", rd_valid); end
        checks++; if (rd_rising !== 1'b0) begin errors++; $display("FAIL rsthi_fall_pol got %0d exp 0", rd_rising); end
        checks++; if (rd_stamp !== 32'd502) begin errors++; $display("FAIL rsthi_fall_stamp got %0d exp 502", rd_stamp); end
        pop();
    endtask

    task automatic test_mid_reset();
        cap_in = 1'b1;
        steps(2);
        cap_in = 1'b0;
        steps(3);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL mid_pre_level got %0d exp 2", level); end
        cap_in = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_async_level got %0d exp 0", level); end
        step();
        reset_n = 1'b1;
        steps(6);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %0d exp 0", rd_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_stale_level got %0d exp 0", level); end
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL mid_lost got %0d exp 0", lost); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_both();
        test_overflow();
        test_disable();
        test_overrun();
        test_reset_high();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_capture.md
# input_capture

Timestamps edges on an external input against the free-running value of our `count` timer and queues the results for a consumer. It is the read side of the timer: `count` produces the timebase and overflow pulses, and this block samples them when an event occurs. A typical use is pulse-width or period measurement, with software or a downstream FSM draining the FIFO through a valid/ready port.

## Interface
- `COUNTER_SIZE`, default 32: width of the timebase and of captured timestamps.
- `FIFO_DEPTH`, default 4: number of capture entries; must be a power of two and at least 2.
- `OVF_BITS`, default 8: width of the saturating timebase-overflow count stored with each entry.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: gates event detection only.
- `edge_mode`, in, 2: event select. 00 = off, 01 = rising, 10 = falling, 11 = both.
- `cap_in`, in, 1: asynchronous external input.
- `timebase`, in, COUNTER_SIZE: current timer count.
- `timebase_ovf`, in, 1: timer overflow; counted once per cycle it is high.
- `rd_ready`, in, 1: consumer accepts the head entry.
- `clear_lost`, in, 1: clears `lost`.
- `rd_valid`, out, 1: FIFO not empty.
- `rd_stamp`, out, COUNTER_SIZE: head entry timestamp.
- `rd_ovf`, out, OVF_BITS: head entry overflow count.
- `rd_rising`, out, 1: head entry polarity. 1 = rising, 0 = falling.
- `level`, out, clog2(FIFO_DEPTH)+1: number of occupied entries.
- `lost`, out, 1: sticky flag; at least one event was dropped.

## Operation
- **Synchronizer.** `cap_in` passes through 2 flops (s1, s2), then a history flop s3. All three reset to 0.
- **Priming.**
  - A `primed` flag sets 3 cycles after reset release.
  - While not primed, detection is suppressed. This stops a high `cap_in` at reset from producing a false rising edge.
- **Edge detection.**
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An event fires when all hold: primed, `enable`, and the edge type is selected by `edge_mode`.
- **Overflow accumulator.**
  - Increments when `timebase_ovf` is high, saturating at all-ones.
  - An accepted capture stores the accumulator value, then the accumulator restarts.
  - If `timebase_ovf` coincides with an accepted capture, the stored value excludes it and the accumulator restarts at 1; otherwise it restarts at 0.
- **Capture.** On an event, the FIFO pushes {`timebase` in the detect cycle, accumulator, rise}.
- **FIFO.**
  - A pop occurs when `rd_valid` and `rd_ready` are both high.
  - Event while full with no pop in the same cycle: the event is dropped, `lost` is set, and the accumulator is unchanged (it keeps counting).
  - Event while full with a pop in the same cycle: the push is accepted and `level` stays at FIFO_DEPTH.
  - Push and pop in the same cycle when not full: `level` is unchanged.
- **lost flag.**
  - `clear_lost` clears it.
  - A new drop in the same cycle as `clear_lost` wins, so `lost` stays 1.
- **Disable behaviour.**
  - With `enable` low or `edge_mode` = 00, the synchronizer and accumulator keep running.
  - FIFO contents stay readable.
  - Re-enabling does not replay edges that occurred while disabled.
- **Reset.** Reset mid-operation empties the FIFO, clears `lost`, the accumulator and `primed`, and discards any in-flight edge.

## Timing
- Output reset values: `rd_valid` = 0, `rd_stamp` = 0, `rd_ovf` = 0, `rd_rising` = 0, `level` = 0, `lost` = 0.
- Latency: a `cap_in` transition sampled at edge k is detected in the cycle after edge k+1 and written at edge k+2. `rd_valid` rises after edge k+2.
- Timestamp: the `timebase` value present during the detect cycle.
- Read path: `rd_*` are registered FIFO head outputs and are stable while `rd_valid` is high and `rd_ready` is low. The next entry appears the cycle after a pop.
- Minimum spacing: one event per cycle. Pulses shorter than one clock may be missed; this is not an error.

## Structure
- **Package** `input_capture_pkg`:
  - edge-mode constants EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - the capture-entry struct {stamp, ovf, rising};
  - the synchronizer depth constant SYNC_STAGES = 2.
- **Sub-module** `cap_fifo`: a synchronous FIFO parameterized by width and depth. It provides push/pop, registered head, level and full, and implements the simultaneous push/pop-when-full rule.
- Top level: synchronizer, priming, edge detection, accumulator and the `lost` logic.

## Test plan
- **Basic rising capture.** `edge_mode` = 01, `timebase` incrementing from 100, `cap_in` rises at edge 10 → `rd_valid` after edge 12, `rd_stamp` = 100 + the detect-cycle offset, `rd_rising` = 1, `rd_ovf` = 0.
- **Both edges.** `edge_mode` = 11, a 5-cycle high pulse → two entries, rising then falling, with stamps differing by 5.
- **Overflow accumulation.** Three `timebase_ovf` pulses, then an edge → `rd_ovf` = 3. A fourth pulse coinciding with the next edge → that entry's `rd_ovf` = 0, and the following entry includes the coincident overflow.
- **Overrun.** `rd_ready` = 0 with 6 edges and FIFO_DEPTH = 4 → `level` = 4, `lost` = 1, and the first 4 stamps are retained in order. An edge with a simultaneous pop when full → accepted. `clear_lost` → `lost` = 0.
- **Reset with `cap_in` high.** Hold `cap_in` = 1 through reset release → no entry produced. A subsequent fall is captured with `rd_rising` = 0.
- **Mid-operation reset.** Assert reset with 2 entries queued and one edge in the synchronizer → after release, `level` = 0, `rd_valid` = 0, and no stale entry appears.
